// File: rtl/cm0_dap_cdc_send_hs_if.sv
// Sending-side handshake bundle for cm0_dap_cdc_send_hs: local valid/ready word port,
// launched data, far-domain request/acknowledge and busy status.
interface cm0_dap_cdc_send_hs_if #(
    parameter int unsigned WIDTH = 8
);
    logic             sendvalid;
    logic [WIDTH-1:0] senddata;
    logic             sendready;
    logic [WIDTH-1:0] regdo;
    logic             reqo;
    logic             acki;
    logic             busy;

    // master: local word source plus far-domain acknowledger; slave: the launch block
    modport master (
        output sendvalid, senddata, acki,
        input  sendready, regdo, reqo, busy
    );
    modport slave (
        input  sendvalid, senddata, acki,
        output sendready, regdo, reqo, busy
    );
endinterface

// File: rtl/cm0_dap_cdc_send_hs.sv
// Multi-bit CDC launch register with req/ack handshake (4-phase or 2-phase toggle).
// Optional one-entry skid buffer enabled by defining CM0_DAP_CDC_SEND_SKID_EN.
module cm0_dap_cdc_send_hs #(
    parameter int unsigned PRESENT     = 1,
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FOUR_PHASE  = 1
) (
    input logic                 regclk,
    input logic                 rarregreset,
    cm0_dap_cdc_send_hs_if.slave hs
);

    typedef enum logic [1:0] {StIdle, StWaitAck, StWaitRel} state_e;

    if (PRESENT != 0) begin : g_present
        state_e                 state_q, state_d;
        logic [SYNC_STAGES-1:0] ack_sync_q;
        logic                   ack_s;
        logic                   accept;
        logic                   ack_done;
        logic                   pending;
        logic                   launch;
        logic                   reqo_q, reqo_d;
        logic [WIDTH-1:0]       regdo_q;
        logic [WIDTH-1:0]       launch_data;
        logic                   skid_v;
        logic                   sendready;
        logic                   busy;

        // ACKI is sampled only here
        always_ff @(posedge regclk or posedge rarregreset) begin
            if (rarregreset) ack_sync_q <= '0;
            else             ack_sync_q <= {ack_sync_q[SYNC_STAGES-2:0], hs.acki};
        end
        assign ack_s = ack_sync_q[SYNC_STAGES-1];

        assign accept  = hs.sendvalid && sendready;
        assign pending = skid_v || accept;

        // State register
        always_ff @(posedge regclk or posedge rarregreset) begin
            if (rarregreset) state_q <= StIdle;
            else             state_q <= state_d;
        end

        // Next state; ack_done marks the edge on which the handshake completes
        always_comb begin
            state_d  = state_q;
            ack_done = 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (accept) state_d = StWaitAck;
                end
                StWaitAck: begin
                    if (FOUR_PHASE != 0) begin
                        if (ack_s) state_d = StWaitRel;
                    end else if (ack_s == reqo_q) begin
                        ack_done = 1'b1;
                    end
                end
                StWaitRel: begin
                    if (!ack_s) ack_done = 1'b1;
                end
                default: state_d = StIdle;
            endcase
            if (ack_done) state_d = pending ? StWaitAck : StIdle;
        end

        // Outputs decoded from state
        always_comb begin
`ifdef CM0_DAP_CDC_SEND_SKID_EN
            sendready = (state_q == StIdle) || !skid_v;
`else
            sendready = (state_q == StIdle);
`endif
            busy = (state_q != StIdle) || skid_v;
        end

        // A completing handshake relaunches straight away if a word is waiting
        assign launch = ((state_q == StIdle) && accept) || (ack_done && pending);

        always_comb begin
            reqo_d = reqo_q;
            if (launch) begin
                reqo_d = (FOUR_PHASE != 0) ? 1'b1 : !reqo_q;
            end else if ((FOUR_PHASE != 0) && (state_q == StWaitAck) && ack_s) begin
                reqo_d = 1'b0;
            end
        end

        always_ff @(posedge regclk or posedge rarregreset) begin
            if (rarregreset) reqo_q <= 1'b0;
            else             reqo_q <= reqo_d;
        end

        // Hold-enable register: REGDO only moves on a launch edge
        always_ff @(posedge regclk or posedge rarregreset) begin
            if (rarregreset)  regdo_q <= '0;
            else if (launch)  regdo_q <= launch_data;
        end

`ifdef CM0_DAP_CDC_SEND_SKID_EN
        logic             skid_valid_q;
        logic [WIDTH-1:0] skid_q;
        logic             buf_wr;

        assign buf_wr = accept && (state_q != StIdle) && !ack_done;

        always_ff @(posedge regclk or posedge rarregreset) begin
            if (rarregreset) begin
                skid_valid_q <= 1'b0;
                skid_q       <= '0;
            end else if (buf_wr) begin
                skid_valid_q <= 1'b1;
                skid_q       <= hs.senddata;
            end else if (ack_done && skid_valid_q) begin
                skid_valid_q <= 1'b0;
            end
        end

        assign skid_v      = skid_valid_q;
        assign launch_data = skid_valid_q ? skid_q : hs.senddata;
`else
        assign skid_v      = 1'b0;
        assign launch_data = hs.senddata;
`endif

        assign hs.sendready = sendready;
        assign hs.busy      = busy;
        assign hs.reqo      = reqo_q;
        assign hs.regdo     = regdo_q;
    end else begin : g_absent
        assign hs.sendready = 1'b1;
        assign hs.busy      = 1'b0;
        assign hs.reqo      = 1'b0;
        assign hs.regdo     = '0;
    end

endmodule

// File: tb/tb_cm0_dap_cdc_send_hs.sv
// Self-checking bench for cm0_dap_cdc_send_hs: a 4-phase, a 2-phase and an absent instance
// compared cycle by cycle against a handshake reference model with a randomised far side.
module tb_cm0_dap_cdc_send_hs;

    localparam int W = 8;
`ifdef CM0_DAP_CDC_SEND_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cm0_dap_cdc_send_hs_if #(.WIDTH(W)) bus4 ();
    cm0_dap_cdc_send_hs_if #(.WIDTH(W)) bus2 ();
    cm0_dap_cdc_send_hs_if #(.WIDTH(W)) bus0 ();

    cm0_dap_cdc_send_hs #(.PRESENT(1), .WIDTH(W), .SYNC_STAGES(2), .FOUR_PHASE(1)) u4 (
        .regclk(clk), .rarregreset(rst), .hs(bus4));
    cm0_dap_cdc_send_hs #(.PRESENT(1), .WIDTH(W), .SYNC_STAGES(3), .FOUR_PHASE(0)) u2 (
        .regclk(clk), .rarregreset(rst), .hs(bus2));
    cm0_dap_cdc_send_hs #(.PRESENT(0), .WIDTH(W), .SYNC_STAGES(2), .FOUR_PHASE(1)) u0 (
        .regclk(clk), .rarregreset(rst), .hs(bus0));

    logic         vin [3];
    logic [W-1:0] din [3];
    logic         ain [3];
    logic         o_rdy [3];
    logic         o_req [3];
    logic         o_busy [3];
    logic [W-1:0] o_do [3];

    assign bus4.sendvalid = vin[0]; assign bus4.senddata = din[0]; assign bus4.acki = ain[0];
    assign bus2.sendvalid = vin[1]; assign bus2.senddata = din[1]; assign bus2.acki = ain[1];
    assign bus0.sendvalid = vin[2]; assign bus0.senddata = din[2]; assign bus0.acki = ain[2];
    assign o_rdy[0] = bus4.sendready; assign o_req[0] = bus4.reqo;
    assign o_busy[0] = bus4.busy;     assign o_do[0] = bus4.regdo;
    assign o_rdy[1] = bus2.sendready; assign o_req[1] = bus2.reqo;
    assign o_busy[1] = bus2.busy;     assign o_do[1] = bus2.regdo;
    assign o_rdy[2] = bus0.sendready; assign o_req[2] = bus0.reqo;
    assign o_busy[2] = bus0.busy;     assign o_do[2] = bus0.regdo;

    int checks = 0;
    int failures = 0;

    // Reference model: phase 0 = idle, 1 = awaiting ack, 2 = awaiting ack release
    int           m_ph [2];
    logic         m_req [2];
    logic         m_mv [2];
    logic [W-1:0] m_do [2];
    logic [W-1:0] m_buf [2];
    logic [7:0]   m_ahist [2];   // bit j = ACKI seen j+1 edges ago

    function automatic int four_phase_of(input int k); return (k == 0) ? 1 : 0; endfunction
    function automatic int stages_of(input int k);     return (k == 0) ? 2 : 3; endfunction
    function automatic bit m_ready(input int k);
        return (m_ph[k] == 0) || (SKID && !m_mv[k]);
    endfunction
    function automatic bit m_busy(input int k);
        return (m_ph[k] != 0) || m_mv[k];
    endfunction

    always @(posedge clk or posedge rst) begin : model
        int ph; logic req, mv, acks, acc, rel, go; logic [W-1:0] dout, bf, nxt;
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_ph[k] <= 0; m_req[k] <= 1'b0; m_mv[k] <= 1'b0;
                m_do[k] <= '0; m_buf[k] <= '0; m_ahist[k] <= '0;
            end else begin
                ph = m_ph[k]; req = m_req[k]; mv = m_mv[k]; dout = m_do[k]; bf = m_buf[k];
                acks = m_ahist[k][stages_of(k)-1];
                acc  = vin[k] && m_ready(k);
                rel  = 1'b0; go = 1'b0; nxt = din[k];
                if (ph == 0) begin
                    go = acc;
                end else if (ph == 1) begin
                    if (four_phase_of(k) == 1) begin
                        if (acks) begin req = 1'b0; ph = 2; end
                    end else if (acks == req) rel = 1'b1;
                end else if (!acks) rel = 1'b1;
                if (acc && ph != 0 && !rel) begin bf = din[k]; mv = 1'b1; end
                if (rel) begin
                    if (mv) begin go = 1'b1; nxt = bf; mv = 1'b0; end
                    else if (acc) go = 1'b1;
                    else ph = 0;
                end
                if (go) begin
                    dout = nxt; ph = 1;
                    req = (four_phase_of(k) == 1) ? 1'b1 : !req;
                end
                m_ph[k] <= ph; m_req[k] <= req; m_mv[k] <= mv; m_do[k] <= dout; m_buf[k] <= bf;
                m_ahist[k] <= {m_ahist[k][6:0], ain[k]};
            end
        end
    end

    // Far-domain responder: mirrors REQO onto ACKI after a random latency
    bit far_auto [2];
    int far_cnt [2];
    int far_lat [2];

    task automatic tick();
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            if (far_auto[k]) begin
                if (ain[k] != o_req[k]) begin
                    if (far_cnt[k] >= far_lat[k]) begin
                        ain[k] = o_req[k]; far_cnt[k] = 0; far_lat[k] = $urandom_range(0, 4);
                    end else far_cnt[k]++;
                end else far_cnt[k] = 0;
            end
        end
    endtask

    task automatic wait_idle(input int k, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (o_rdy[k] === 1'b1 && o_busy[k] === 1'b0 && m_ph[k] == 0 && !m_mv[k]) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin vin[k] = 1'b0; din[k] = '0; ain[k] = 1'b0; end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        tick();
        for (int k = 0; k < 3; k++) begin
            checks++; if (o_do[k] !== '0)   begin failures++; $display("FAIL reset_regdo k=%0d got=%h exp=00", k, o_do[k]); end
            checks++; if (o_req[k] !== 1'b0) begin failures++; $display("FAIL reset_reqo k=%0d got=%b exp=0", k, o_req[k]); end
            checks++; if (o_rdy[k] !== 1'b1) begin failures++; $display("FAIL reset_ready k=%0d got=%b exp=1", k, o_rdy[k]); end
            checks++; if (o_busy[k] !== 1'b0) begin failures++; $display("FAIL reset_busy k=%0d got=%b exp=0", k, o_busy[k]); end
        end
    endtask

    task automatic test_four_phase();
        bit ok;
        far_auto[0] = 1'b0; ain[0] = 1'b0;
        wait_idle(0, ok);
        checks++; if (!ok) begin failures++; $display("FAIL fp_idle_timeout got=busy exp=idle"); end
        din[0] = 8'hA5; vin[0] = 1'b1;
        tick();
        vin[0] = 1'b0; din[0] = 8'h00;
        checks++; if (o_req[0] !== 1'b1)  begin failures++; $display("FAIL fp_req_rise got=%b exp=1", o_req[0]); end
        checks++; if (o_do[0] !== 8'hA5)  begin failures++; $display("FAIL fp_regdo got=%h exp=a5", o_do[0]); end
        checks++; if (o_rdy[0] !== 1'b0)  begin failures++; $display("FAIL fp_ready_low got=%b exp=0", o_rdy[0]); end
        repeat (4) tick();
        ain[0] = 1'b1;
        for (int i = 0; i < 20 && o_req[0] === 1'b1; i++) begin
            tick();
            checks++;
            if (o_req[0] !== m_req[0] || o_do[0] !== 8'hA5) begin
                failures++; $display("FAIL fp_wait_ack req=%b exp=%b regdo=%h exp=a5", o_req[0], m_req[0], o_do[0]);
            end
        end
        checks++; if (o_req[0] !== 1'b0) begin failures++; $display("FAIL fp_req_fall got=%b exp=0", o_req[0]); end
        ain[0] = 1'b0;
        for (int i = 0; i < 20 && o_rdy[0] !== 1'b1; i++) begin
            tick();
            checks++;
            if (o_rdy[0] !== m_ready(0) || o_do[0] !== 8'hA5) begin
                failures++; $display("FAIL fp_wait_rel ready=%b exp=%b regdo=%h exp=a5", o_rdy[0], m_ready(0), o_do[0]);
            end
        end
        checks++; if (o_rdy[0] !== 1'b1 || o_busy[0] !== 1'b0) begin
            failures++; $display("FAIL fp_ready_return ready=%b busy=%b exp=1/0", o_rdy[0], o_busy[0]);
        end
    endtask

    task automatic test_two_phase();
        bit ok; int changes; logic [W-1:0] prev;
        logic [W-1:0] words [2];
        words[0] = 8'h3C; words[1] = 8'hC3;
        far_auto[1] = 1'b1; far_lat[1] = 2;
        wait_idle(1, ok);
        changes = 0; prev = o_do[1];
        for (int w = 0; w < 2; w++) begin
            din[1] = words[w]; vin[1] = 1'b1;
            for (int i = 0; i < 60 && vin[1]; i++) begin
                if (m_ready(1)) begin tick(); vin[1] = 1'b0; end
                else tick();
                checks++;
                if (o_req[1] !== m_req[1] || o_do[1] !== m_do[1] || o_rdy[1] !== m_ready(1)) begin
                    failures++;
                    $display("FAIL tp_cycle req=%b exp=%b regdo=%h exp=%h ready=%b exp=%b",
                             o_req[1], m_req[1], o_do[1], m_do[1], o_rdy[1], m_ready(1));
                end
                if (o_do[1] !== prev) begin changes++; prev = o_do[1]; end
            end
            checks++; if (o_do[1] !== words[w]) begin failures++; $display("FAIL tp_word%0d got=%h exp=%h", w, o_do[1], words[w]); end
            checks++; if (o_req[1] !== ((w == 0) ? 1'b1 : 1'b0)) begin
                failures++; $display("FAIL tp_toggle%0d got=%b exp=%b", w, o_req[1], (w == 0));
            end
        end
        wait_idle(1, ok);
        checks++; if (!ok) begin failures++; $display("FAIL tp_idle_timeout got=busy exp=idle"); end
        checks++; if (changes != 2) begin failures++; $display("FAIL tp_regdo_changes got=%0d exp=2", changes); end
    endtask

    task automatic test_hold_while_busy();
        bit ok; bit acc;
        far_auto[0] = 1'b1; far_lat[0] = 3;
        wait_idle(0, ok);
        din[0] = 8'h5A; vin[0] = 1'b1;
        tick();
        din[0] = 8'hFF;
        for (int i = 0; i < 40; i++) begin
            acc = vin[0] && m_ready(0);
            tick();
            if (acc) vin[0] = 1'b0;
            checks++;
            if (o_do[0] !== m_do[0] || o_rdy[0] !== m_ready(0) || o_busy[0] !== m_busy(0)) begin
                failures++;
                $display("FAIL hold_cycle regdo=%h exp=%h ready=%b exp=%b busy=%b exp=%b",
                         o_do[0], m_do[0], o_rdy[0], m_ready(0), o_busy[0], m_busy(0));
            end
        end
        checks++; if (o_do[0] !== 8'hFF) begin failures++; $display("FAIL hold_final got=%h exp=ff", o_do[0]); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        far_auto[0] = 1'b0; ain[0] = 1'b0;
        wait_idle(0, ok);
        din[0] = 8'h77; vin[0] = 1'b1;
        tick();
        vin[0] = 1'b0;
        checks++; if (o_req[0] !== 1'b1) begin failures++; $display("FAIL rm_req_high got=%b exp=1", o_req[0]); end
        #2 rst = 1'b1;
        #1;
        checks++; if (o_req[0] !== 1'b0) begin failures++; $display("FAIL rm_async_reqo got=%b exp=0", o_req[0]); end
        checks++; if (o_do[0] !== '0)    begin failures++; $display("FAIL rm_async_regdo got=%h exp=00", o_do[0]); end
        for (int k = 0; k < 2; k++) begin ain[k] = 1'b0; vin[k] = 1'b0; far_cnt[k] = 0; end
        @(negedge clk);
        rst = 1'b0;
        tick();
        far_auto[0] = 1'b1;
        din[0] = 8'h11; vin[0] = 1'b1;
        tick();
        vin[0] = 1'b0;
        checks++; if (o_do[0] !== 8'h11 || o_req[0] !== 1'b1) begin
            failures++; $display("FAIL rm_resume regdo=%h req=%b exp=11/1", o_do[0], o_req[0]);
        end
        wait_idle(0, ok);
        checks++; if (!ok) begin failures++; $display("FAIL rm_idle_timeout got=busy exp=idle"); end
    endtask

    task automatic test_random();
        bit acc [2];
        far_auto[0] = 1'b1; far_auto[1] = 1'b1;
        for (int i = 0; i < 400; i++) begin
            for (int k = 0; k < 2; k++) acc[k] = vin[k] && m_ready(k);
            tick();
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (o_req[k] !== m_req[k] || o_do[k] !== m_do[k] ||
                    o_rdy[k] !== m_ready(k) || o_busy[k] !== m_busy(k)) begin
                    failures++;
                    $display("FAIL rand_cycle k=%0d req=%b/%b regdo=%h/%h ready=%b/%b busy=%b/%b (got/exp)",
                             k, o_req[k], m_req[k], o_do[k], m_do[k], o_rdy[k], m_ready(k),
                             o_busy[k], m_busy(k));
                end
                // the source holds an offered word until it is taken
                if (acc[k] || !vin[k]) begin
                    vin[k] = ($urandom_range(0, 2) != 0);
                    din[k] = W'($urandom);
                end
            end
        end
        vin[0] = 1'b0; vin[1] = 1'b0;
    endtask

`ifdef CM0_DAP_CDC_SEND_SKID_EN
    task automatic test_skid();
        bit ok;
        far_auto[0] = 1'b0;
        wait_idle(0, ok);
        ain[0] = 1'b0;
        repeat (4) tick();
        din[0] = 8'h01; vin[0] = 1'b1;
        tick();
        din[0] = 8'h02;
        tick();
        vin[0] = 1'b0;
        checks++; if (o_rdy[0] !== 1'b0 || o_busy[0] !== 1'b1 || o_do[0] !== 8'h01) begin
            failures++; $display("FAIL skid_buffered ready=%b busy=%b regdo=%h exp=0/1/01",
                                 o_rdy[0], o_busy[0], o_do[0]);
        end
        ain[0] = 1'b1;
        for (int i = 0; i < 20 && o_req[0] === 1'b1; i++) tick();
        ain[0] = 1'b0;
        for (int i = 0; i < 20 && o_do[0] !== 8'h02; i++) begin
            tick();
            checks++; if (o_do[0] !== m_do[0] || o_req[0] !== m_req[0]) begin
                failures++; $display("FAIL skid_cycle regdo=%h exp=%h req=%b exp=%b", o_do[0], m_do[0], o_req[0], m_req[0]);
            end
        end
        checks++; if (o_do[0] !== 8'h02 || o_req[0] !== 1'b1) begin
            failures++; $display("FAIL skid_relaunch regdo=%h req=%b exp=02/1", o_do[0], o_req[0]);
        end
        far_auto[0] = 1'b1;
        wait_idle(0, ok);
    endtask
`endif

    task automatic test_absent();
        for (int i = 0; i < 20; i++) begin
            vin[2] = $urandom_range(0, 1); din[2] = W'($urandom); ain[2] = $urandom_range(0, 1);
            tick();
            checks++;
            if (o_do[2] !== '0 || o_req[2] !== 1'b0 || o_busy[2] !== 1'b0 || o_rdy[2] !== 1'b1) begin
                failures++; $display("FAIL absent_tieoff regdo=%h req=%b busy=%b ready=%b exp=00/0/0/1",
                                     o_do[2], o_req[2], o_busy[2], o_rdy[2]);
            end
        end
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin far_auto[k] = 1'b0; far_cnt[k] = 0; far_lat[k] = 1; end
        test_reset();
        test_four_phase();
        test_two_phase();
        test_hold_while_busy();
        test_reset_mid();
`ifdef CM0_DAP_CDC_SEND_SKID_EN
        test_skid();
`endif
        test_random();
        test_absent();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
